// File: rtl/cipher_pkg.sv
// Shared LFSR defaults and the Fibonacci step function
// used by the keystream cipher and its LFSR core.
package cipher_pkg;

    localparam int LFSR_MAX_W = 64;

    localparam logic [7:0] DEFAULT_TAPS_8 = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED_8 = 8'hCD;

    // Callers zero-extend to LFSR_MAX_W and truncate the result to their width.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps
    );
        logic fb;
        fb = ^(state & taps);
        return {state[LFSR_MAX_W-2:0], fb};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with seed load, zero-seed rejection
// and a step enable; the state never becomes zero.
module lfsr_core
    import cipher_pkg::*;
#(
    parameter int                LFSR_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = DEFAULT_TAPS_8,
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED_8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              step_i,
    output logic [LFSR_W-1:0] state_o,
    output logic              seed_err_o
);

    logic [LFSR_W-1:0] state_q, state_d;
    logic              err_q, err_d;

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        if (load_i) begin
            if (seed_i == '0) begin
                state_d = SEED;
                err_d   = 1'b1;
            end else begin
                state_d = seed_i;
            end
        end else if (step_i) begin
            state_d = LFSR_W'(lfsr_next(LFSR_MAX_W'(state_q),
                                        LFSR_MAX_W'(TAPS)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign state_o    = state_q;
    assign seed_err_o = err_q;

endmodule

// File: rtl/lfsr_stream_cipher.sv
// LFSR keystream cipher: XORs each accepted word with the keystream,
// with valid/ready on both sides, bypass and a ciphered-beat counter.
module lfsr_stream_cipher
    import cipher_pkg::*;
#(
    parameter int                LFSR_W = 8,
    parameter int                DATA_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = DEFAULT_TAPS_8,
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED_8,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_seed,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              bypass,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [DATA_W-1:0] m_ks,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              seed_err
);

    if (DATA_W > LFSR_W) begin : g_bad_data_w
        $error("DATA_W must not exceed LFSR_W");
    end
    if (LFSR_W < 4) begin : g_bad_lfsr_w
        $error("LFSR_W must be at least 4");
    end

    logic [LFSR_W-1:0] state;
    logic [DATA_W-1:0] ks;
    logic              accept;
    logic              step;

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [DATA_W-1:0] m_ks_q, m_ks_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign s_ready = (!m_valid_q || m_ready) && !load_seed;
    assign accept  = s_valid && s_ready;
    assign step    = accept && !bypass;
    assign ks      = state[DATA_W-1:0];

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_seed),
        .seed_i     (seed_in),
        .step_i     (step),
        .state_o    (state),
        .seed_err_o (seed_err)
    );

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ks_d    = m_ks_q;
        cnt_d     = cnt_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = bypass ? s_data : (s_data ^ ks);
            m_ks_d    = bypass ? '0 : ks;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
        // A seed load restarts the count; it never coincides with an accept.
        if (load_seed) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ks_q    <= '0;
            cnt_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ks_q    <= m_ks_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_ks     = m_ks_q;
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Directed bench for lfsr_stream_cipher with hand-computed
// keystream values for taps B8 (CD,9A,35 and A5,4A,95).
module tb_lfsr_stream_cipher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_seed = 1'b0;
    logic [7:0]  seed_in = 8'h00;
    logic        bypass = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic [7:0]  m_ks;
    logic [15:0] beat_cnt;
    logic        seed_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lfsr_stream_cipher dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_seed (load_seed),
        .seed_in   (seed_in),
        .bypass    (bypass),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_ks      (m_ks),
        .beat_cnt  (beat_cnt),
        .seed_err  (seed_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load_seed = 1'b0;
        bypass = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        m_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [7:0] s);
        s_valid = 1'b0;
        load_seed = 1'b1;
        seed_in = s;
        tick();
        load_seed = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({m_valid, m_data, m_ks, beat_cnt, seed_err} !== 34'h0) begin
            n_err++;
            $display("FAIL reset: v=%b d=%h ks=%h cnt=%0d err=%b exp all 0",
                     m_valid, m_data, m_ks, beat_cnt, seed_err);
        end
        do_reset();
    endtask

    task automatic test_stream();
        logic [7:0] exp_d[3] = '{8'hCD, 8'h9A, 8'h35};
        do_reset();
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (m_valid !== 1'b1 || m_data !== exp_d[i] || m_ks !== exp_d[i]) begin
                n_err++;
                $display("FAIL stream[%0d]: v=%b d=%h ks=%h exp d=ks=%h",
                         i, m_valid, m_data, m_ks, exp_d[i]);
            end
        end
        s_valid = 1'b0;
        n_vec++;
        if (beat_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL stream_cnt: got %0d exp 3", beat_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        s_valid = 1'b1;
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (s_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_ready[%0d]: got %b exp 0", i, s_ready);
            end
            tick();
            n_vec++;
            if (m_valid !== 1'b1 || m_data !== 8'hCD || beat_cnt !== 16'd1) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: v=%b d=%h cnt=%0d exp 1 CD 1",
                         i, m_valid, m_data, beat_cnt);
            end
        end
        m_ready = 1'b1;
        tick();
        n_vec++;
        if (m_data !== 8'h9A) begin
            n_err++;
            $display("FAIL bp_resume1: got %h exp 9A", m_data);
        end
        tick();
        n_vec++;
        if (m_data !== 8'h35) begin
            n_err++;
            $display("FAIL bp_resume2: got %h exp 35", m_data);
        end
        s_valid = 1'b0;
        tick();
        n_vec++;
        if (m_valid !== 1'b0 || beat_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL bp_end: v=%b cnt=%0d exp 0 3", m_valid, beat_cnt);
        end
    endtask

    task automatic test_round_trip();
        logic [7:0] pt[3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] ct[3] = '{8'hB4, 8'h68, 8'hA6};
        logic [7:0] kx[3] = '{8'hA5, 8'h4A, 8'h95};
        do_reset();
        load(8'hA5);
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = pt[i];
            tick();
            n_vec++;
            if (m_data !== ct[i] || m_ks !== kx[i]) begin
                n_err++;
                $display("FAIL enc[%0d]: d=%h ks=%h exp %h %h",
                         i, m_data, m_ks, ct[i], kx[i]);
            end
        end
        load(8'hA5);
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = ct[i];
            tick();
            n_vec++;
            if (m_data !== pt[i]) begin
                n_err++;
                $display("FAIL dec[%0d]: got %h exp %h", i, m_data, pt[i]);
            end
        end
        s_valid = 1'b0;
        s_data = 8'h00;
        tick();
    endtask

    task automatic test_zero_seed();
        load(8'h00);
        n_vec++;
        if (seed_err !== 1'b1 || beat_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL zseed: err=%b cnt=%0d exp 1 0", seed_err, beat_cnt);
        end
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        n_vec++;
        if (seed_err !== 1'b0 || m_ks !== 8'hCD || m_data !== 8'hCD) begin
            n_err++;
            $display("FAIL zseed_next: err=%b ks=%h d=%h exp 0 CD CD",
                     seed_err, m_ks, m_data);
        end
    endtask

    task automatic test_bypass();
        logic [7:0] exp_d[3] = '{8'hCD, 8'h00, 8'h9A};
        logic       byp[3] = '{1'b0, 1'b1, 1'b0};
        do_reset();
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bypass = byp[i];
            tick();
            n_vec++;
            if (m_data !== exp_d[i] || m_ks !== exp_d[i]) begin
                n_err++;
                $display("FAIL byp[%0d]: d=%h ks=%h exp %h",
                         i, m_data, m_ks, exp_d[i]);
            end
        end
        s_valid = 1'b0;
        bypass = 1'b0;
        n_vec++;
        if (beat_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL byp_cnt: got %0d exp 2", beat_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        s_valid = 1'b1;
        s_data = 8'h5A;
        tick();
        s_valid = 1'b0;
        m_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: v=%b exp 0", m_valid);
        end
        tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data = 8'h00;
        tick();
        s_valid = 1'b0;
        n_vec++;
        if (m_ks !== 8'hCD || beat_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL rst_mid_next: ks=%h cnt=%0d exp CD 1", m_ks, beat_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_round_trip();
        test_zero_seed();
        test_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
